uart_rx_deser: RTL
==================

# uart_rx_deser

UART receive deserializer for the iCEBreaker ALU-over-UART design. It samples the asynchronous RX pin, recovers 8N1 frames at a fixed clocks-per-bit ratio (280 clocks at 32.256 MHz gives 115200 baud), and presents each byte on a ready/valid stream. The packet/ALU logic consumes that stream. It is the far end of the host-side serial transmitter that drives RX.

## Interface
- CLKS_PER_BIT, 280, clock cycles per UART bit; even, ≥ 8.
- clk_i  in  1  system clock (PLL output, 32.256 MHz).
- rst_ni  in  1  reset; asynchronous and active-low.
- rx_i  in  1  serial input, idle high, asynchronous to clk_i.
- data_o  out  8  received byte, LSB first on the wire.
- valid_o  out  1  data_o holds an unconsumed byte.
- ready_i  in  1  consumer accepts data_o this cycle.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- overrun_o  out  1  one-cycle pulse: byte dropped because valid_o was still pending.
- busy_o  out  1  high whenever the FSM is not in IDLE.

## Operation
- rx_i passes through a 2-flop synchronizer; both flops reset to 1. All FSM decisions use the synchronized value rx_s.
- Bit counter cnt covers 0..CLKS_PER_BIT-1. Bit index idx covers 0..7. Shift register sr is 8 bits.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: when rx_s = 0, go to START with cnt = 0.
- START: increment cnt.
  - At cnt = CLKS_PER_BIT/2 - 1, sample rx_s.
  - If rx_s = 1, it was a glitch: go to IDLE with no output.
  - If rx_s = 0, go to DATA with cnt = 0 and idx = 0.
- DATA: increment cnt.
  - At cnt = CLKS_PER_BIT-1, set sr = {rx_s, sr[7:1]} and cnt = 0.
  - After the sample with idx = 7, go to STOP. Otherwise increment idx.
- STOP: at cnt = CLKS_PER_BIT-1, sample rx_s.
  - If rx_s = 1, deliver the byte and go to IDLE.
  - If rx_s = 0, pulse frame_err_o, discard sr, and go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s = 1, then go to IDLE. A held-low line (break) never produces bytes.
- Byte delivery:
  - If valid_o = 0, or valid_o = 1 and ready_i = 1 in the same cycle: load data_o = sr and set valid_o = 1.
  - If valid_o = 1 and ready_i = 0: keep the old data_o, drop the new byte, and pulse overrun_o.
- Handshake:
  - A transfer occurs on a clock edge where valid_o & ready_i.
  - valid_o falls after that edge unless a byte is delivered on the same edge.
  - data_o is stable while valid_o & !ready_i.
  - ready_i is ignored while valid_o = 0.
- Reset asserted mid-frame: FSM goes to IDLE immediately. cnt, idx and sr clear. valid_o, frame_err_o, overrun_o and busy_o go to 0, and data_o to 0x00. The partial frame is lost. After release, the receiver waits for the next falling edge of rx_s.

## Timing
- Reset values:
  - data_o = 0x00
  - valid_o = 0, frame_err_o = 0, overrun_o = 0, busy_o = 0
  - synchronizer flops = 1
- Edge numbering: E0 is the first clock edge that registers rx_i = 0. rx_s = 0 after E1. The FSM leaves IDLE at E2.
- Start sample is at E2 + CLKS_PER_BIT/2.
- Data bit k (k = 1..8) is sampled at E2 + CLKS_PER_BIT/2 + k·CLKS_PER_BIT.
- Stop sample is at E2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT. valid_o or frame_err_o is high in the cycle after this edge.
  - For CLKS_PER_BIT = 280, that is the cycle after E0 + 2662.
- Sampling the stop bit at mid-bit returns the FSM to IDLE half a bit early. This tolerates back-to-back frames and about ±4% baud mismatch.
- busy_o rises the cycle after E2. It falls the cycle after the stop sample, or after leaving WAIT_IDLE.
- Throughput: one byte per 10·CLKS_PER_BIT cycles. A consumer with ready_i tied high never sees an overrun.

## Test plan
- Reset, ready_i = 1, send 0xA5 at 280 clk/bit: valid_o high for exactly 1 cycle, at E0 + 2663 ±1, with data_o = 0xA5 and no error pulses.
- Back-to-back 0x00, 0xFF, 0x3C with no idle gap: three valid beats in order, spaced 2800 cycles apart, with data 0x00, 0xFF, 0x3C.
- rx_i low for 50 cycles then high: no valid_o and no frame_err_o, busy_o falls by cycle 145, and a following 0x5A is received correctly.
- Frame 0x81 with stop bit 0, then line high: frame_err_o pulses once, valid_o stays 0, and a following 0x81 with a correct stop bit is delivered.
- ready_i = 0, send 0x11 then 0x22: valid_o stays high with data_o = 0x11 and overrun_o pulses once. Raising ready_i gives one transfer of 0x11, then valid_o = 0.
- Assert rst_ni low during bit 4 of 0xC3, then release: all outputs return to reset values, nothing is delivered for the broken frame, and the next 0xC3 is received as 0xC3.

Source files
------------

// File: rtl/uart_rx_deser.sv
// UART 8N1 receive deserializer: 2-flop RX synchronizer, mid-bit sampling
// FSM, byte output on a valid/ready stream with frame/overrun error pulses.
// Ports: clk_i, rst_ni (async low), rx_i (serial in, idle high),
//        data_o/valid_o/ready_i (byte stream), frame_err_o, overrun_o, busy_o.
module uart_rx_deser #(
  parameter int CLKS_PER_BIT = 280
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sr;
  logic          rx_m;
  logic          rx_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      sr          <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      // A delivery below on the same edge overrides this drop.
      if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state  <= START;
            cnt    <= '0;
            busy_o <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (rx_s) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else begin
              state <= DATA;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt <= '0;
            sr  <= {rx_s, sr[7:1]};
            if (idx == 3'd7) begin
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state  <= IDLE;
              busy_o <= 1'b0;
              if (!valid_o || ready_i) begin
                data_o  <= sr;
                valid_o <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
            end else begin
              // Stop bit low: drop the byte and wait out any break.
              state       <= WAIT_IDLE;
              frame_err_o <= 1'b1;
              sr          <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
